hex_keypad_entry: RTL and testbench
===================================

HEX_KEYPAD_ENTRY -- requirements
Module: hex_keypad_entry

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, giving the number of clk cycles per scan tick.
REQ-002 The block SHALL have parameter DEB_TICKS, default 4, giving the number of consecutive identical scan samples required to accept a press or a release.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port clr, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port row, output, 4 bits: keypad row drive, active-low, exactly one bit low at any time.
REQ-006 The block SHALL have port col, input, 4 bits: keypad column sense, active-low, externally pulled up, asynchronous to clk.
REQ-007 The block SHALL have ports input1, input2, input3 and input4, each output, 4 bits: entered hex digits, with input4 the oldest and input1 the newest, wired directly to the display driver digit inputs.
REQ-008 The block SHALL have port key_code, output, 4 bits: hex value of the last accepted key.
REQ-009 The block SHALL have port key_valid, output, 1 bit: a one-cycle pulse when a key is accepted.

Function
REQ-010 The block SHALL pass col through a 2-flop synchronizer, and only the synchronized value SHALL be used.
REQ-011 A tick counter SHALL count 0..SCAN_DIV-1 and wrap; tick SHALL be asserted for one cycle when the count equals SCAN_DIV-1.
REQ-012 The column sample SHALL be taken on the tick cycle, for the row currently driven.
REQ-013 A sample SHALL count as a hit only when exactly one synchronized col bit is low; zero or more than one low bit SHALL count as no key.
REQ-014 The key map, indexed [row][col], SHALL be: r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = 0,F,E,D.
REQ-015 The FSM SHALL have four states: SCAN, PRESS_DEB, HELD and REL_DEB.
REQ-016 In SCAN, on a tick with no hit, the active row SHALL advance 0->1->2->3->0.
REQ-017 In SCAN, on a tick with a hit, the FSM SHALL latch the candidate row/col, set the debounce count to 1, go to PRESS_DEB, and hold the row.
REQ-018 In PRESS_DEB, on each tick, a hit at the same col SHALL increment the count, and any other sample SHALL return the FSM to SCAN with the row advanced.
REQ-019 In PRESS_DEB, when the count reaches DEB_TICKS, the FSM SHALL accept the key and go to HELD.
REQ-020 On the cycle after acceptance, key_valid SHALL be 1 for exactly one cycle and key_code SHALL equal the mapped value.
REQ-021 On that same cycle, the digits SHALL shift: input4<=input3, input3<=input2, input2<=input1, input1<=key.
REQ-022 In HELD, the row SHALL remain driven, and the first tick with the latched col high SHALL go to REL_DEB with count 1.
REQ-023 In REL_DEB, on each tick, the latched col high SHALL increment the count, and the latched col low SHALL return the FSM to HELD.
REQ-024 In REL_DEB, count = DEB_TICKS SHALL go to SCAN with the row advanced.
REQ-025 A held key SHALL produce exactly one key_valid, with no auto-repeat.
REQ-026 Presses on other keys while in HELD or REL_DEB SHALL be ignored.
REQ-027 The digit register SHALL have no overflow condition: the fifth and later keys shift out the oldest digit.
REQ-028 The debounce counter SHALL be wide enough for DEB_TICKS and SHALL never wrap.

Reset
REQ-029 While clr=1 at a rising edge, the block SHALL load: state=SCAN, row=4'b1110, tick count=0, debounce count=0, synchronizer flops=4'hF, input1..input4=0, key_code=0, key_valid=0.
REQ-030 Reset asserted in any state, including mid-debounce or while a key is held, SHALL abort the operation with no key_valid.
REQ-031 After reset, a key still held SHALL be detected as a new press.

Structure
REQ-032 The state encodings, the key-map table and the default parameter values SHALL reside in a shared package, keypad_pkg.
REQ-033 The tick generator SHALL be a sub-module, scan_tick, with ports clk, clr and tick, and parameter N=SCAN_DIV.
REQ-034 The synchronizer, FSM and digit shift register SHALL be implemented in the top module.

Verification (SCAN_DIV=4, DEB_TICKS=3)
REQ-035 The bench SHALL cover a reset-then-idle case: col=4'hF -> row cycles 1110,1101,1011,0111 with one step every 4 clks, key_valid never asserted, and digits 0000.
REQ-036 The bench SHALL cover a clean press of key 5 (row1/col1) held 20 ticks then released -> exactly one key_valid, key_code=5, input1=5, and scanning resumes after 3 high ticks.
REQ-037 The bench SHALL cover the entry sequence A,3,0,F -> input4..input1 = A,3,0,F; a fifth key 7 -> 3,0,F,7.
REQ-038 The bench SHALL cover bounce: col toggling low/high every tick for 10 ticks, then stable low -> exactly one key_valid, issued 3 stable ticks after the bounce ends.
REQ-039 The bench SHALL cover a two-key press in the same row (col=4'b1100) -> no key_valid, and the row keeps advancing.
REQ-040 The bench SHALL cover clr asserted during PRESS_DEB and during HELD -> state SCAN, row 1110, digits 0 and no pulse; the key still held afterwards -> one key_valid after 3 ticks.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the hex keypad entry block.
// Holds the default parameter values, the FSM state encoding and the key map.
// The key map is indexed [row][col], for example KEY_MAP[1][1] = 5.
package keypad_pkg;

    localparam int unsigned SCAN_DIV_DEF  = 50000;
    localparam int unsigned DEB_TICKS_DEF = 4;
    localparam int unsigned KEY_W         = 4;
    localparam int unsigned NUM_ROWS      = 4;
    localparam int unsigned NUM_COLS      = 4;

    typedef enum logic [1:0] {
        ST_SCAN      = 2'd0,
        ST_PRESS_DEB = 2'd1,
        ST_HELD      = 2'd2,
        ST_REL_DEB   = 2'd3
    } state_t;

    // Written as {row3, row2, row1, row0}; each row is written as {col3, col2, col1, col0}.
    localparam logic [NUM_ROWS-1:0][NUM_COLS-1:0][KEY_W-1:0] KEY_MAP = {
        {4'hD, 4'hE, 4'hF, 4'h0},
        {4'hC, 4'h9, 4'h8, 4'h7},
        {4'hB, 4'h6, 4'h5, 4'h4},
        {4'hA, 4'h3, 4'h2, 4'h1}
    };

    function automatic logic [KEY_W-1:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        return KEY_MAP[r][c];
    endfunction

endpackage

// File: rtl/hex_keypad_entry_if.sv
// Bundle for the keypad and display signals of hex_keypad_entry.
//   master: the entry block. It drives row, the digits, key_code and key_valid, and it senses col.
//   slave : the keypad and display side.
interface hex_keypad_entry_if;
    import keypad_pkg::*;

    logic [NUM_ROWS-1:0] row;
    logic [NUM_COLS-1:0] col;
    logic [KEY_W-1:0]    input1;
    logic [KEY_W-1:0]    input2;
    logic [KEY_W-1:0]    input3;
    logic [KEY_W-1:0]    input4;
    logic [KEY_W-1:0]    key_code;
    logic                key_valid;

    modport master (output row, input1, input2, input3, input4, key_code, key_valid,
                    input  col);
    modport slave  (input  row, input1, input2, input3, input4, key_code, key_valid,
                    output col);
endinterface

// File: rtl/scan_tick.sv
// Scan tick generator.
// The counter runs 0..N-1 and wraps. tick is high during the cycle in which the count equals N-1.
//   clk  : system clock
//   clr  : synchronous active-high reset
//   tick : one-cycle pulse every N clocks
module scan_tick
    import keypad_pkg::*;
#(
    parameter int unsigned N = SCAN_DIV_DEF
) (
    input  logic clk,
    input  logic clr,
    output logic tick
);
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(N - 1));
    assign tick   = w_last;

    always_ff @(posedge clk) begin
        if (clr)         r_cnt <= '0;
        else if (w_last) r_cnt <= '0;
        else             r_cnt <= r_cnt + CW'(1);
    end
endmodule

// File: rtl/hex_keypad_entry.sv
// Hex keypad scanner with debounce and a four-digit entry shift register.
//   clk       : system clock
//   clr       : synchronous active-high reset
//   row       : active-low row drive; exactly one bit is low
//   col       : active-low column sense; asynchronous to clk
//   input1..4 : entered digits; input1 is the newest and input4 the oldest
//   key_code  : value of the last accepted key
//   key_valid : one-cycle pulse on the cycle after a key is accepted
module hex_keypad_entry
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = SCAN_DIV_DEF,
    parameter int unsigned DEB_TICKS = DEB_TICKS_DEF
) (
    input  logic                clk,
    input  logic                clr,
    output logic [NUM_ROWS-1:0] row,
    input  logic [NUM_COLS-1:0] col,
    output logic [KEY_W-1:0]    input1,
    output logic [KEY_W-1:0]    input2,
    output logic [KEY_W-1:0]    input3,
    output logic [KEY_W-1:0]    input4,
    output logic [KEY_W-1:0]    key_code,
    output logic                key_valid
);
    localparam int unsigned DW = $clog2(DEB_TICKS + 1);

    logic [NUM_COLS-1:0] r_col_s1, r_col_s2;
    state_t              r_state, w_state_nx;
    logic [1:0]          r_row_idx, w_row_nx;
    logic [1:0]          r_cand_col, w_cand_nx;
    logic [DW-1:0]       r_deb_cnt, w_deb_nx, w_deb_inc;
    logic [KEY_W-1:0]    r_dig1, r_dig2, r_dig3, r_dig4, r_key_code;
    logic                r_key_valid;
    logic                w_tick, w_hit, w_cand_high, w_accept;
    logic [NUM_COLS-1:0] w_col_low;
    logic [1:0]          w_hit_col;

    scan_tick #(.N(SCAN_DIV)) u_scan_tick (
        .clk  (clk),
        .clr  (clr),
        .tick (w_tick)
    );

    // Two-flop synchronizer for the asynchronous column lines.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_col_s1 <= '1;
            r_col_s2 <= '1;
        end else begin
            r_col_s1 <= col;
            r_col_s2 <= r_col_s1;
        end
    end

    // A sample is a hit only when exactly one column is low.
    assign w_col_low   = ~r_col_s2;
    assign w_hit       = $onehot(w_col_low);
    assign w_cand_high = r_col_s2[r_cand_col];
    assign w_deb_inc   = r_deb_cnt + DW'(1);

    always_comb begin
        w_hit_col = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (w_col_low[i]) w_hit_col = 2'(i);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= ST_SCAN;
            r_row_idx  <= '0;
            r_cand_col <= '0;
            r_deb_cnt  <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_row_idx  <= w_row_nx;
            r_cand_col <= w_cand_nx;
            r_deb_cnt  <= w_deb_nx;
        end
    end

    // FSM next state. Everything advances only on scan ticks.
    always_comb begin
        w_state_nx = r_state;
        w_row_nx   = r_row_idx;
        w_cand_nx  = r_cand_col;
        w_deb_nx   = r_deb_cnt;
        w_accept   = 1'b0;
        if (w_tick) begin
            unique case (r_state)
                ST_SCAN: begin
                    if (w_hit) begin
                        w_cand_nx = w_hit_col;
                        w_deb_nx  = DW'(1);
                        if (DEB_TICKS <= 1) begin
                            w_accept   = 1'b1;
                            w_state_nx = ST_HELD;
                        end else begin
                            w_state_nx = ST_PRESS_DEB;
                        end
                    end else begin
                        w_row_nx = r_row_idx + 2'd1;
                    end
                end
                ST_PRESS_DEB: begin
                    if (w_hit && (w_hit_col == r_cand_col)) begin
                        w_deb_nx = w_deb_inc;
                        if (w_deb_inc == DW'(DEB_TICKS)) begin
                            w_accept   = 1'b1;
                            w_state_nx = ST_HELD;
                        end
                    end else begin
                        w_state_nx = ST_SCAN;
                        w_row_nx   = r_row_idx + 2'd1;
                        w_deb_nx   = '0;
                    end
                end
                ST_HELD: begin
                    // Only the latched column matters, so other keys in this row are ignored.
                    if (w_cand_high) begin
                        w_deb_nx = DW'(1);
                        if (DEB_TICKS <= 1) begin
                            w_state_nx = ST_SCAN;
                            w_row_nx   = r_row_idx + 2'd1;
                            w_deb_nx   = '0;
                        end else begin
                            w_state_nx = ST_REL_DEB;
                        end
                    end
                end
                ST_REL_DEB: begin
                    if (w_cand_high) begin
                        if (w_deb_inc == DW'(DEB_TICKS)) begin
                            w_state_nx = ST_SCAN;
                            w_row_nx   = r_row_idx + 2'd1;
                            w_deb_nx   = '0;
                        end else begin
                            w_deb_nx = w_deb_inc;
                        end
                    end else begin
                        w_state_nx = ST_HELD;
                    end
                end
                default: w_state_nx = ST_SCAN;
            endcase
        end
    end

    // Key output and digit shift register. The digits update on the same cycle as the pulse.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
            r_dig1      <= '0;
            r_dig2      <= '0;
            r_dig3      <= '0;
            r_dig4      <= '0;
        end else begin
            r_key_valid <= w_accept;
            if (w_accept) begin
                r_key_code <= key_lookup(r_row_idx, w_hit_col);
                r_dig4     <= r_dig3;
                r_dig3     <= r_dig2;
                r_dig2     <= r_dig1;
                r_dig1     <= key_lookup(r_row_idx, w_hit_col);
            end
        end
    end

    assign row       = ~(4'b0001 << r_row_idx);
    assign input1    = r_dig1;
    assign input2    = r_dig2;
    assign input3    = r_dig3;
    assign input4    = r_dig4;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
endmodule

// File: tb/tb_hex_keypad_entry.sv
// Self-checking bench for hex_keypad_entry with SCAN_DIV=4 and DEB_TICKS=3.
// The keypad is modelled as a set of pressed switches. Expected digits come from a four-entry history.
module tb_hex_keypad_entry;
    localparam int TK = 4;   // clocks per scan tick

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic [15:0] pressed = '0;   // bit r*4+c is set while the key at row r, col c is held
    int checks = 0;
    int failures = 0;
    int pulses = 0;
    logic [3:0] last_code = '0;
    logic prev_valid = 1'b0;
    int exp_dig [4];             // index 0 is input1 (newest)
    int kv [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

    hex_keypad_entry_if kp ();

    hex_keypad_entry #(.SCAN_DIV(4), .DEB_TICKS(3)) dut (
        .clk       (clk),
        .clr       (clr),
        .row       (kp.row),
        .col       (kp.col),
        .input1    (kp.input1),
        .input2    (kp.input2),
        .input3    (kp.input3),
        .input4    (kp.input4),
        .key_code  (kp.key_code),
        .key_valid (kp.key_valid)
    );

    always #5 clk = ~clk;

    // Switch matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        kp.col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!kp.row[r] && pressed[r*4+c]) kp.col[c] = 1'b0;
    end

    // Pulse monitor, sampled shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        if (kp.key_valid === 1'b1) begin
            pulses++;
            last_code = kp.key_code;
            if (prev_valid) begin
                checks++;
                failures++;
                $display("FAIL pulse_width: key_valid high for 2 or more cycles, required 1");
            end
        end
        prev_valid = (kp.key_valid === 1'b1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] exp_digits();
        return {4'(exp_dig[3]), 4'(exp_dig[2]), 4'(exp_dig[1]), 4'(exp_dig[0])};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) exp_dig[i] = 0;
    endtask

    task automatic model_shift(input int v);
        for (int i = 3; i > 0; i--) exp_dig[i] = exp_dig[i-1];
        exp_dig[0] = v;
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits for the pulse count to exceed base. n returns bound+1 on timeout.
    task automatic wait_pulse(input int base, input int bound, output int n);
        n = bound + 1;
        for (int i = 0; i <= bound; i++) begin
            if (pulses > base) begin
                n = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Press the key at (r, c), hold it, release it and let the release debounce finish.
    task automatic enter_key(input int r, input int c, input int hold_ticks);
        pressed[r*4+c] = 1'b1;
        clks(hold_ticks * TK);
        pressed = '0;
        clks(7 * TK);
        model_shift(kv[r*4+c]);
    endtask

    task automatic test_reset();
        logic [3:0] prev;
        int gap, steps;
        clr = 1'b1;
        clks(3);
        checks++;
        if (kp.row !== 4'b1110) begin failures++; $display("FAIL reset_row: got %b want 1110", kp.row); end
        checks++;
        if ({kp.input4, kp.input3, kp.input2, kp.input1, kp.key_code, kp.key_valid} !== 21'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h%h%h%h code=%h valid=%b want all 0",
                     kp.input4, kp.input3, kp.input2, kp.input1, kp.key_code, kp.key_valid);
        end
        clr = 1'b0;
        model_clear();
        // Idle: the row rotates one step per tick.
        prev = kp.row;
        gap = 0;
        steps = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            gap++;
            if (kp.row !== prev) begin
                checks++;
                if (kp.row !== {prev[2:0], prev[3]} || (steps > 0 && gap != TK)) begin
                    failures++;
                    $display("FAIL idle_scan: row %b->%b after %0d clks, want %b after %0d",
                             prev, kp.row, gap, {prev[2:0], prev[3]}, TK);
                end
                steps++;
                gap = 0;
                prev = kp.row;
            end
        end
        checks++;
        if (steps < 9) begin failures++; $display("FAIL idle_steps: got %0d want >=9", steps); end
        checks++;
        if (pulses != 0 || {kp.input4, kp.input3, kp.input2, kp.input1} !== 16'h0) begin
            failures++;
            $display("FAIL idle_quiet: pulses=%0d digits=%h want 0 and 0000", pulses,
                     {kp.input4, kp.input3, kp.input2, kp.input1});
        end
    endtask

    task automatic test_key5();
        int base, n;
        base = pulses;
        pressed[5] = 1'b1;
        clks(20 * TK);
        checks++;
        if (pulses - base != 1) begin failures++; $display("FAIL key5_count: got %0d want 1", pulses - base); end
        checks++;
        if (last_code !== 4'h5 || kp.key_code !== 4'h5 || kp.input1 !== 4'h5) begin
            failures++;
            $display("FAIL key5_code: code=%h input1=%h want 5", kp.key_code, kp.input1);
        end
        checks++;
        if (kp.row !== 4'b1101) begin failures++; $display("FAIL key5_row_held: got %b want 1101", kp.row); end
        pressed = '0;
        clks(8);
        checks++;
        if (kp.row !== 4'b1101) begin failures++; $display("FAIL rel_too_early: got %b want 1101", kp.row); end
        n = 13;
        for (int i = 0; i < 12; i++) begin
            if (kp.row !== 4'b1101) begin n = i; break; end
            @(negedge clk);
        end
        checks++;
        if (n > 12 || kp.row !== 4'b1011) begin
            failures++;
            $display("FAIL rel_resume: row=%b after %0d clks, want 1011 within 12", kp.row, n + 8);
        end
        model_shift(5);
        clks(2 * TK);
    endtask

    task automatic test_sequence();
        enter_key(0, 3, 10);
        enter_key(0, 2, 10);
        enter_key(3, 0, 10);
        enter_key(3, 1, 10);
        checks++;
        if ({kp.input4, kp.input3, kp.input2, kp.input1} !== 16'hA30F) begin
            failures++;
            $display("FAIL seq_4keys: got %h want a30f", {kp.input4, kp.input3, kp.input2, kp.input1});
        end
        enter_key(2, 0, 10);
        checks++;
        if ({kp.input4, kp.input3, kp.input2, kp.input1} !== 16'h30F7) begin
            failures++;
            $display("FAIL seq_5th: got %h want 30f7", {kp.input4, kp.input3, kp.input2, kp.input1});
        end
    endtask

    task automatic test_bounce();
        int base, n;
        base = pulses;
        for (int i = 0; i < 10; i++) begin
            pressed[9] = (i % 2 == 0);
            clks(TK);
        end
        checks++;
        if (pulses != base) begin failures++; $display("FAIL bounce_quiet: got %0d pulses want 0", pulses - base); end
        pressed[9] = 1'b1;
        wait_pulse(base, 40, n);
        checks++;
        if (n < 2 * TK || n > 40) begin
            failures++;
            $display("FAIL bounce_latency: got %0d clks want 8..40", n);
        end
        clks(10 * TK);
        checks++;
        if (pulses - base != 1 || last_code !== 4'h8) begin
            failures++;
            $display("FAIL bounce_key: got %0d pulses code %h want 1 pulse code 8", pulses - base, last_code);
        end
        pressed = '0;
        clks(7 * TK);
        model_shift(8);
    endtask

    task automatic test_two_key();
        int base, moves;
        logic [3:0] prev;
        base = pulses;
        pressed[0] = 1'b1;
        pressed[1] = 1'b1;
        clks(2 * TK);
        moves = 0;
        prev = kp.row;
        for (int i = 0; i < 12 * TK; i++) begin
            @(negedge clk);
            if (kp.row !== prev) moves++;
            prev = kp.row;
        end
        checks++;
        if (pulses != base || moves < 11) begin
            failures++;
            $display("FAIL two_key: pulses=%0d row_moves=%0d want 0 and >=11", pulses - base, moves);
        end
        pressed = '0;
        clks(2 * TK);
    endtask

    task automatic test_reset_abort();
        int base, n;
        pressed[10] = 1'b1;
        n = 41;
        for (int i = 0; i < 40; i++) begin
            if (kp.row === 4'b1011) begin n = i; break; end
            @(negedge clk);
        end
        checks++;
        if (n > 40) begin failures++; $display("FAIL abort_reach_row: row 1011 not seen, got %b", kp.row); end
        clks(6);
        for (int phase = 0; phase < 2; phase++) begin
            base = pulses;
            clr = 1'b1;
            clks(2);
            checks++;
            if (kp.row !== 4'b1110 || {kp.input4, kp.input3, kp.input2, kp.input1} !== 16'h0 ||
                kp.key_code !== 4'h0 || kp.key_valid !== 1'b0 || pulses != base) begin
                failures++;
                $display("FAIL abort_clr%0d: row=%b digits=%h code=%h pulses=%0d want 1110 0000 0 0",
                         phase, kp.row, {kp.input4, kp.input3, kp.input2, kp.input1}, kp.key_code,
                         pulses - base);
            end
            clr = 1'b0;
            model_clear();
            wait_pulse(base, 60, n);
            checks++;
            if (n < 2 * TK || n > 60 || last_code !== 4'h9) begin
                failures++;
                $display("FAIL abort_repress%0d: latency=%0d code=%h want 8..60 and 9", phase, n, last_code);
            end
            model_shift(9);
            clks(4 * TK);
            checks++;
            if (pulses - base != 1 || {kp.input4, kp.input3, kp.input2, kp.input1} !== exp_digits()) begin
                failures++;
                $display("FAIL abort_after%0d: pulses=%0d digits=%h want 1 and %h", phase, pulses - base,
                         {kp.input4, kp.input3, kp.input2, kp.input1}, exp_digits());
            end
        end
        pressed = '0;
        clks(7 * TK);
    endtask

    task automatic test_random();
        int base, r, c;
        for (int it = 0; it < 6; it++) begin
            base = pulses;
            r = $urandom_range(3, 0);
            c = $urandom_range(3, 0);
            enter_key(r, c, $urandom_range(14, 10));
            checks++;
            if (pulses - base != 1 || last_code !== 4'(kv[r*4+c]) ||
                {kp.input4, kp.input3, kp.input2, kp.input1} !== exp_digits()) begin
                failures++;
                $display("FAIL random_%0d: key r%0d c%0d pulses=%0d code=%h digits=%h want 1 %h %h",
                         it, r, c, pulses - base, last_code,
                         {kp.input4, kp.input3, kp.input2, kp.input1}, 4'(kv[r*4+c]), exp_digits());
            end
        end
    endtask

    initial begin
        test_reset();
        test_key5();
        test_sequence();
        test_bounce();
        test_two_key();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
